// File: rtl/ram_pkg.sv
// Shared definitions for the dual-port pixel RAM and its fill engine.
package ram_pkg;

    localparam int RD_FIRST = 0;
    localparam int WR_FIRST = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fill_state_e;

endpackage

// File: rtl/ram_fill_fsm.sv
// Fill engine: sweeps every word of the array to a captured constant and
// owns the array write port, muxing between the user writer and the sweep.
module ram_fill_fsm
    import ram_pkg::*;
#(
    parameter int DATA_W = 12,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 20
) (
    input  logic              i_clk,
    input  logic              i_rstN,
    input  logic              i_fillStart,
    input  logic [DATA_W-1:0] i_fillValue,
    input  logic              i_userWe,
    input  logic [ADDR_W-1:0] i_userAddr,
    input  logic [DATA_W-1:0] i_userData,
    output logic              o_memWe,
    output logic [ADDR_W-1:0] o_memAddr,
    output logic [DATA_W-1:0] o_memData,
    output logic              o_fillBusy,
    output logic              o_fillDone
);

    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(DEPTH - 1);

    fill_state_e       r_state;
    fill_state_e       w_nextState;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] w_nextPtr;
    logic [DATA_W-1:0] r_fillValue;
    logic [DATA_W-1:0] w_nextFillValue;
    logic              w_userInRange;

    assign w_userInRange = ({1'b0, i_userAddr} < DEPTH_EXT);

    always_ff @(posedge i_clk) begin
        if (!i_rstN) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_fillValue <= '0;
        end else begin
            r_state     <= w_nextState;
            r_ptr       <= w_nextPtr;
            r_fillValue <= w_nextFillValue;
        end
    end

    // User writes reach the array outside FILL only; the sweep owns the port while busy.
    always_comb begin
        w_nextState     = r_state;
        w_nextPtr       = r_ptr;
        w_nextFillValue = r_fillValue;
        o_memWe         = 1'b0;
        o_memAddr       = i_userAddr;
        o_memData       = i_userData;
        o_fillBusy      = 1'b0;
        o_fillDone      = 1'b0;
        case (r_state)
            IDLE: begin
                o_memWe = i_userWe && w_userInRange;
                if (i_fillStart) begin
                    w_nextState     = FILL;
                    w_nextPtr       = '0;
                    w_nextFillValue = i_fillValue;
                end
            end
            FILL: begin
                o_fillBusy = 1'b1;
                o_memWe    = 1'b1;
                o_memAddr  = r_ptr;
                o_memData  = r_fillValue;
                if (r_ptr == LAST_PTR) begin
                    w_nextState = DONE;
                end else begin
                    w_nextPtr = r_ptr + 1'b1;
                end
            end
            DONE: begin
                o_fillDone  = 1'b1;
                o_memWe     = i_userWe && w_userInRange;
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/ram_sync_dp_fill.sv
// Simple dual-port synchronous pixel RAM with collision mode, optional
// output register and a built-in screen-clear fill engine.
module ram_sync_dp_fill
    import ram_pkg::*;
#(
    parameter int DATA_W  = 12,
    parameter int DEPTH   = 1024,
    parameter int ADDR_W  = 20,
    parameter int RD_MODE = 0,
    parameter int OUT_REG = 0
) (
    input  logic              clk_d,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] din,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              fill_start,
    input  logic [DATA_W-1:0] fill_value,
    output logic              fill_busy,
    output logic              fill_done
);

    localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_memWe;
    logic [ADDR_W-1:0] w_memAddr;
    logic [DATA_W-1:0] w_memData;
    logic              w_wrEn;
    logic              w_rdInRange;
    logic              w_collide;
    logic [DATA_W-1:0] w_rdWord;
    logic [DATA_W-1:0] r_rd1Data;
    logic              r_rd1Valid;

    ram_fill_fsm #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fillFsm (
        .i_clk       (clk_d),
        .i_rstN      (rst_n),
        .i_fillStart (fill_start),
        .i_fillValue (fill_value),
        .i_userWe    (we),
        .i_userAddr  (waddr),
        .i_userData  (din),
        .o_memWe     (w_memWe),
        .o_memAddr   (w_memAddr),
        .o_memData   (w_memData),
        .o_fillBusy  (fill_busy),
        .o_fillDone  (fill_done)
    );

    // Writes are held off on a reset edge so an aborted fill stops exactly at its pointer.
    assign w_wrEn      = w_memWe && rst_n;
    assign w_rdInRange = ({1'b0, raddr} < DEPTH_EXT);
    assign w_collide   = w_wrEn && (w_memAddr == raddr);

    always_ff @(posedge clk_d) begin
        if (w_wrEn) begin
            r_mem[w_memAddr[IDX_W-1:0]] <= w_memData;
        end
    end

    always_comb begin
        w_rdWord = '0;
        if (w_rdInRange) begin
            if ((RD_MODE != RD_FIRST) && w_collide) begin
                w_rdWord = w_memData;
            end else begin
                w_rdWord = r_mem[raddr[IDX_W-1:0]];
            end
        end
    end

    always_ff @(posedge clk_d) begin
        if (!rst_n) begin
            r_rd1Data  <= '0;
            r_rd1Valid <= 1'b0;
        end else begin
            r_rd1Valid <= re;
            if (re) begin
                r_rd1Data <= w_rdWord;
            end
        end
    end

    if (OUT_REG != 0) begin : g_outReg
        logic [DATA_W-1:0] r_rd2Data;
        logic              r_rd2Valid;

        always_ff @(posedge clk_d) begin
            if (!rst_n) begin
                r_rd2Data  <= '0;
                r_rd2Valid <= 1'b0;
            end else begin
                r_rd2Valid <= r_rd1Valid;
                if (r_rd1Valid) begin
                    r_rd2Data <= r_rd1Data;
                end
            end
        end

        assign dout       = r_rd2Data;
        assign dout_valid = r_rd2Valid;
    end else begin : g_noOutReg
        assign dout       = r_rd1Data;
        assign dout_valid = r_rd1Valid;
    end

endmodule

// File: tb/tb_ram_sync_dp_fill.sv
// Scoreboard bench: two RAM instances (read-first/latency 1 and
// write-first/latency 2) share one stimulus stream; monitors pop expectations.
module tb_ram_sync_dp_fill;

    localparam int DATA_W = 12;
    localparam int DEPTH  = 20;
    localparam int ADDR_W = 20;

    typedef struct {
        logic [DATA_W-1:0] data;
        int                due;
    } exp_t;

    logic              clk_d      = 1'b0;
    logic              rst_n      = 1'b0;
    logic              we         = 1'b0;
    logic [ADDR_W-1:0] waddr      = '0;
    logic [DATA_W-1:0] din        = '0;
    logic              re         = 1'b0;
    logic [ADDR_W-1:0] raddr      = '0;
    logic              fill_start = 1'b0;
    logic [DATA_W-1:0] fill_value = '0;

    logic [DATA_W-1:0] dout0, dout1;
    logic              dv0, dv1, busy0, busy1, done0, done1;

    int   cycle    = 0;
    int   checks   = 0;
    int   errors   = 0;
    bit   countEn  = 1'b0;
    int   busyCnt0 = 0;
    int   busyCnt1 = 0;
    int   doneCnt0 = 0;
    int   doneCnt1 = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;

    ram_sync_dp_fill #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .RD_MODE(0), .OUT_REG(0)
    ) dut0 (
        .clk_d(clk_d), .rst_n(rst_n), .we(we), .waddr(waddr), .din(din),
        .re(re), .raddr(raddr), .dout(dout0), .dout_valid(dv0),
        .fill_start(fill_start), .fill_value(fill_value),
        .fill_busy(busy0), .fill_done(done0)
    );

    ram_sync_dp_fill #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .RD_MODE(1), .OUT_REG(1)
    ) dut1 (
        .clk_d(clk_d), .rst_n(rst_n), .we(we), .waddr(waddr), .din(din),
        .re(re), .raddr(raddr), .dout(dout1), .dout_valid(dv1),
        .fill_start(fill_start), .fill_value(fill_value),
        .fill_busy(busy1), .fill_done(done1)
    );

    always #5 clk_d = ~clk_d;

    always @(posedge clk_d) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drives one cycle at posedge+1; a read pushes the hand-computed word for each instance.
    task automatic applyStimulus(input logic iWe, input logic [ADDR_W-1:0] iWaddr,
                                 input logic [DATA_W-1:0] iDin, input logic iRe,
                                 input logic [ADDR_W-1:0] iRaddr,
                                 input logic [DATA_W-1:0] expRdFirst,
                                 input logic [DATA_W-1:0] expWrFirst,
                                 input logic iFill, input logic [DATA_W-1:0] iFillVal);
        exp_t e;
        we         = iWe;
        waddr      = iWaddr;
        din        = iDin;
        re         = iRe;
        raddr      = iRaddr;
        fill_start = iFill;
        fill_value = iFillVal;
        if (iRe) begin
            e.data = expRdFirst;
            e.due  = cycle + 1;
            q0.push_back(e);
            e.data = expWrFirst;
            e.due  = cycle + 2;
            q1.push_back(e);
        end
        @(posedge clk_d);
        #1;
    endtask

    task automatic writeWord(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        applyStimulus(1'b1, a, d, 1'b0, '0, '0, '0, 1'b0, '0);
    endtask

    task automatic readWord(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
        applyStimulus(1'b0, '0, '0, 1'b1, a, exp, exp, 1'b0, '0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, '0, 1'b0, '0);
    endtask

    task automatic startFill(input logic [DATA_W-1:0] v);
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, '0, 1'b1, v);
    endtask

    task automatic clearCounts();
        busyCnt0 = 0;
        busyCnt1 = 0;
        doneCnt0 = 0;
        doneCnt1 = 0;
    endtask

    task automatic checkFillCounts(input string tag, input int expBusy, input int expDone);
        checkOutput({tag, " dut0 fill_busy cycles"}, busyCnt0, expBusy);
        checkOutput({tag, " dut1 fill_busy cycles"}, busyCnt1, expBusy);
        checkOutput({tag, " dut0 fill_done pulses"}, doneCnt0, expDone);
        checkOutput({tag, " dut1 fill_done pulses"}, doneCnt1, expDone);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " dut0 dout"}, dout0, 0);
        checkOutput({tag, " dut0 dout_valid"}, dv0, 0);
        checkOutput({tag, " dut0 fill_busy"}, busy0, 0);
        checkOutput({tag, " dut0 fill_done"}, done0, 0);
        checkOutput({tag, " dut1 dout"}, dout1, 0);
        checkOutput({tag, " dut1 dout_valid"}, dv1, 0);
        checkOutput({tag, " dut1 fill_busy"}, busy1, 0);
        checkOutput({tag, " dut1 fill_done"}, done1, 0);
    endtask

    always @(negedge clk_d) begin
        if (countEn) begin
            busyCnt0 += int'(busy0);
            busyCnt1 += int'(busy1);
            doneCnt0 += int'(done0);
            doneCnt1 += int'(done1);
        end
    end

    always @(negedge clk_d) begin
        if (dv0) begin
            if (q0.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL dut0 unexpected dout_valid: got 1, expected 0 (dout=0x%0h)", dout0);
            end else begin
                e0 = q0.pop_front();
                checkOutput("dut0 dout", dout0, e0.data);
                checkOutput("dut0 read latency cycle", cycle, e0.due);
            end
        end
    end

    always @(negedge clk_d) begin
        if (dv1) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL dut1 unexpected dout_valid: got 1, expected 0 (dout=0x%0h)", dout1);
            end else begin
                e1 = q1.pop_front();
                checkOutput("dut1 dout", dout1, e1.data);
                checkOutput("dut1 read latency cycle", cycle, e1.due);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk_d);
        #1;
        checkAllZero("reset");
        rst_n = 1'b1;

        // Fill addresses 1..19 then stream them back.
        for (int a = 1; a < DEPTH; a++) writeWord(ADDR_W'(a), 12'h123);
        for (int a = 1; a < DEPTH; a++) readWord(ADDR_W'(a), 12'h123);
        idle(3);

        // Same-edge read/write collision at address 5.
        applyStimulus(1'b1, 20'd5, 12'hABC, 1'b1, 20'd5, 12'h123, 12'hABC, 1'b0, '0);
        readWord(20'd5, 12'hABC);
        idle(3);
        checkOutput("hold dut0 dout", dout0, 12'hABC);
        checkOutput("hold dut0 dout_valid", dv0, 0);
        checkOutput("hold dut1 dout", dout1, 12'hABC);
        checkOutput("hold dut1 dout_valid", dv1, 0);

        // Screen clear to zero.
        clearCounts();
        countEn = 1'b1;
        startFill(12'h000);
        idle(24);
        countEn = 1'b0;
        checkFillCounts("fill0", 20, 1);
        for (int a = 0; a < DEPTH; a++) readWord(ADDR_W'(a), 12'h000);
        idle(3);

        // Fill with interference: user write and fill_start while busy, fill_start in DONE.
        clearCounts();
        countEn = 1'b1;
        startFill(12'h2A5);
        for (int i = 1; i <= 24; i++)
            applyStimulus(i == 5, 20'd3, 12'hFFF, 1'b0, '0, '0, '0, (i == 8) || (i == 21), 12'h111);
        countEn = 1'b0;
        checkFillCounts("fill1", 20, 1);
        readWord(20'd3, 12'h2A5);
        readWord(20'd0, 12'h2A5);
        readWord(20'd19, 12'h2A5);
        for (int a = 10; a < DEPTH; a++) writeWord(ADDR_W'(a), 12'h3C3);
        idle(3);

        // Abort a fill with reset when the pointer reaches 10.
        startFill(12'h7E1);
        idle(10);
        rst_n = 1'b0;
        idle(1);
        checkAllZero("reset mid-fill");
        rst_n = 1'b1;
        clearCounts();
        countEn = 1'b1;
        idle(25);
        countEn = 1'b0;
        checkFillCounts("after abort", 0, 0);
        for (int a = 0; a < 10; a++) readWord(ADDR_W'(a), 12'h7E1);
        for (int a = 10; a < DEPTH; a++) readWord(ADDR_W'(a), 12'h3C3);
        idle(3);

        // Out-of-range accesses; 37 would alias onto 5 if the range check were missing.
        writeWord(20'd25, 12'h9F9);
        writeWord(20'd37, 12'h9F9);
        readWord(20'd25, 12'h000);
        readWord(20'd37, 12'h000);
        readWord(20'd5, 12'h7E1);
        idle(4);

        checkOutput("dut0 reads left unanswered", q0.size(), 0);
        checkOutput("dut1 reads left unanswered", q1.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
